reg_file_unit: RTL and testbench
================================

# reg_file_unit

Parametrised general-register file for the VCPU-32 pipeline, the next-generation replacement for the single-word register unit. It holds NUM_REGS words of WORD_LENGTH bits with two registered read ports, one write port with same-cycle write-to-read bypass, a hardwired-zero register 0, and a per-register pending (scoreboard) bit for interlocking in-flight results. It sits between the decode stage, which reads operands and locks destinations, and the write-back stage, which writes results.

## Interface
Parameters:
- WORD_LENGTH, 32, data width in bits
- NUM_REGS, 16, number of registers; power of two, at least 2
- AW, $clog2(NUM_REGS), address width; derived, not overridden

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- rd_en  in  1  sample both read addresses this edge
- raddr_a  in  AW  read port A address
- raddr_b  in  AW  read port B address
- rdata_a  out  WORD_LENGTH  read port A data, registered
- rdata_b  out  WORD_LENGTH  read port B data, registered
- busy_a  out  1  pending bit of raddr_a register, registered with rdata_a
- busy_b  out  1  pending bit of raddr_b register, registered with rdata_b
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  WORD_LENGTH  write data
- lock_en  in  1  set pending bit of lock_addr
- lock_addr  in  AW  register to mark pending
- any_pending  out  1  OR of all pending bits, registered

## Operation
- Storage: NUM_REGS x WORD_LENGTH flops; register 0 always reads 0; writes and locks to address 0 are ignored.
- Write: on edge with we=1 and waddr!=0, reg[waddr] <= wdata and pending[waddr] <= 0.
- Read: on edge with rd_en=1, rdata_x <= value of reg[raddr_x], busy_x <= pending[raddr_x]; with rd_en=0, rdata_x and busy_x hold.
- Bypass: if we=1, waddr==raddr_x, waddr!=0 in the same cycle as rd_en=1, rdata_x captures wdata (not the old value) and busy_x captures 0.
- Lock: on edge with lock_en=1 and lock_addr!=0, pending[lock_addr] <= 1.
- Simultaneous lock and write to same address: lock wins (pending ends 1, data updated); this covers a new producer issued as the old one retires. Bypassed busy_x for that read reports 1.
- Both read ports may address the same register; both return identical data/busy.
- any_pending <= OR of next-state pending bits.
- No arithmetic; addresses are full-range, no wrap or out-of-range case exists.

## Timing
- Reset (rst=1 at edge): all registers 0, all pending 0, rdata_a=rdata_b=0, busy_a=busy_b=0, any_pending=0. rst overrides we, lock_en, rd_en in the same cycle; reset mid-operation discards in-flight writes and locks.
- Read latency: 1 cycle (address at edge N, data valid after edge N).
- Write visible to a read sampled in the same cycle (bypass) and all later ones.
- Lock visible: busy_x=1 for reads sampled on the edge after the lock edge; same-edge lock without write is not bypassed (busy_x reports old pending value, data unaffected).
- any_pending reflects state after the current edge, no extra latency.

## Test plan
- Reset: drive we=1,waddr=3,wdata=32'hDEAD_BEEF,lock_en=1,lock_addr=3 with rst=1 -> after release, read addr 3 returns 0, busy 0, any_pending 0.
- Write/read: write 32'h1234_5678 to reg 5, next cycle rd_en with raddr_a=5, raddr_b=5 -> both rdata = 32'h1234_5678 one cycle later, busy 0.
- Bypass: same cycle we=1,waddr=7,wdata=32'hA5A5_A5A5 and rd_en=1,raddr_a=7 (reg 7 held 32'h1) -> rdata_a=32'hA5A5_A5A5 after that edge.
- Register 0: write 32'hFFFF_FFFF and lock addr 0 -> read addr 0 returns 0, busy 0, any_pending 0.
- Scoreboard: lock reg 4 -> any_pending=1, read 4 gives busy 1; write reg 4 with 32'h42 -> read gives 32'h42, busy 0, any_pending 0.
- Lock+write collision: reg 9 pending, same cycle we to 9 (32'h99) and lock_en to 9 -> data 32'h99, busy 1 on read, any_pending 1.

Source files
------------

// File: rtl/reg_file_unit_if.sv
// Register-file bus for reg_file_unit: two read ports, one write port and a lock port.
// The master side is the pipeline (decode/write-back) and the slave side is the register file.
interface reg_file_unit_if #(
    parameter int WORD_LENGTH = 32,
    parameter int NUM_REGS    = 16
);
    localparam int AW = $clog2(NUM_REGS);

    logic                   rd_en;
    logic [AW-1:0]          raddr_a;
    logic [AW-1:0]          raddr_b;
    logic [WORD_LENGTH-1:0] rdata_a;
    logic [WORD_LENGTH-1:0] rdata_b;
    logic                   busy_a;
    logic                   busy_b;
    logic                   we;
    logic [AW-1:0]          waddr;
    logic [WORD_LENGTH-1:0] wdata;
    logic                   lock_en;
    logic [AW-1:0]          lock_addr;
    logic                   any_pending;

    modport master (
        output rd_en, raddr_a, raddr_b, we, waddr, wdata, lock_en, lock_addr,
        input  rdata_a, rdata_b, busy_a, busy_b, any_pending
    );

    modport slave (
        input  rd_en, raddr_a, raddr_b, we, waddr, wdata, lock_en, lock_addr,
        output rdata_a, rdata_b, busy_a, busy_b, any_pending
    );
endinterface

// File: rtl/reg_file_unit.sv
// VCPU-32 general register file: two registered read ports with write bypass,
// hardwired-zero register 0 and a per-register pending scoreboard.
module reg_file_unit #(
    parameter int WORD_LENGTH = 32,
    parameter int NUM_REGS    = 16
) (
    input logic            clk,
    input logic            rst,
    reg_file_unit_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);

    logic [WORD_LENGTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]    pending;
    logic [NUM_REGS-1:0]    pending_nxt;
    logic                   wr_ok;
    logic                   lock_ok;
    logic                   wr_lock_hit;
    logic                   byp_a;
    logic                   byp_b;

    assign wr_ok       = bus.we && (bus.waddr != '0);
    assign lock_ok     = bus.lock_en && (bus.lock_addr != '0);
    assign wr_lock_hit = lock_ok && (bus.lock_addr == bus.waddr);
    assign byp_a       = wr_ok && (bus.waddr == bus.raddr_a);
    assign byp_b       = wr_ok && (bus.waddr == bus.raddr_b);

    // Lock is applied after the write clear so a same-cycle lock wins.
    always_comb begin
        pending_nxt = pending;
        if (wr_ok)
            pending_nxt[bus.waddr] = 1'b0;
        if (lock_ok)
            pending_nxt[bus.lock_addr] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            pending         <= '0;
            bus.rdata_a     <= '0;
            bus.rdata_b     <= '0;
            bus.busy_a      <= 1'b0;
            bus.busy_b      <= 1'b0;
            bus.any_pending <= 1'b0;
        end else begin
            if (wr_ok)
                regs[bus.waddr] <= bus.wdata;
            pending         <= pending_nxt;
            bus.any_pending <= |pending_nxt;

            if (bus.rd_en) begin
                if (byp_a) begin
                    bus.rdata_a <= bus.wdata;
                    bus.busy_a  <= wr_lock_hit;
                end else begin
                    bus.rdata_a <= regs[bus.raddr_a];
                    bus.busy_a  <= pending[bus.raddr_a];
                end
                if (byp_b) begin
                    bus.rdata_b <= bus.wdata;
                    bus.busy_b  <= wr_lock_hit;
                end else begin
                    bus.rdata_b <= regs[bus.raddr_b];
                    bus.busy_b  <= pending[bus.raddr_b];
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_file_unit.sv
// Directed self-checking bench for reg_file_unit with hand-computed expectations.
module tb_reg_file_unit;
    localparam int WL = 32;
    localparam int NR = 16;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    reg_file_unit_if #(.WORD_LENGTH(WL), .NUM_REGS(NR)) bus ();

    reg_file_unit #(.WORD_LENGTH(WL), .NUM_REGS(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Inputs are driven 1 time unit after the edge; outputs are checked at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_en     = 1'b0;
        bus.raddr_a   = '0;
        bus.raddr_b   = '0;
        bus.we        = 1'b0;
        bus.waddr     = '0;
        bus.wdata     = '0;
        bus.lock_en   = 1'b0;
        bus.lock_addr = '0;
    endtask

    task automatic write(input logic [3:0] a, input logic [31:0] d);
        idle();
        bus.we    = 1'b1;
        bus.waddr = a;
        bus.wdata = d;
        tick();
    endtask

    task automatic read(input logic [3:0] a, input logic [3:0] b);
        idle();
        bus.rd_en   = 1'b1;
        bus.raddr_a = a;
        bus.raddr_b = b;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();

        // Reset overrides a concurrent write and lock.
        rst           = 1'b1;
        bus.we        = 1'b1;
        bus.waddr     = 4'd3;
        bus.wdata     = 32'hDEAD_BEEF;
        bus.lock_en   = 1'b1;
        bus.lock_addr = 4'd3;
        bus.rd_en     = 1'b1;
        bus.raddr_a   = 4'd3;
        tick();
        tick();
        check("rst_rdata_a", bus.rdata_a, 32'h0);
        check("rst_busy_a", {31'b0, bus.busy_a}, 32'h0);
        check("rst_any_pending", {31'b0, bus.any_pending}, 32'h0);
        rst = 1'b0;
        read(4'd3, 4'd3);
        check("post_rst_rd3", bus.rdata_a, 32'h0);
        check("post_rst_busy3", {31'b0, bus.busy_a}, 32'h0);
        check("post_rst_any", {31'b0, bus.any_pending}, 32'h0);

        // Write then read with both ports on the same register.
        write(4'd5, 32'h1234_5678);
        read(4'd5, 4'd5);
        check("wr5_rdata_a", bus.rdata_a, 32'h1234_5678);
        check("wr5_rdata_b", bus.rdata_b, 32'h1234_5678);
        check("wr5_busy_a", {31'b0, bus.busy_a}, 32'h0);
        check("wr5_busy_b", {31'b0, bus.busy_b}, 32'h0);

        // rd_en low holds the previous read results.
        idle();
        bus.raddr_a = 4'd3;
        tick();
        check("hold_rdata_a", bus.rdata_a, 32'h1234_5678);

        // Bypass on port A while port B reads an unrelated register.
        write(4'd7, 32'h1);
        idle();
        bus.we      = 1'b1;
        bus.waddr   = 4'd7;
        bus.wdata   = 32'hA5A5_A5A5;
        bus.rd_en   = 1'b1;
        bus.raddr_a = 4'd7;
        bus.raddr_b = 4'd5;
        tick();
        check("byp_rdata_a", bus.rdata_a, 32'hA5A5_A5A5);
        check("byp_rdata_b", bus.rdata_b, 32'h1234_5678);
        read(4'd5, 4'd7);
        check("after_byp_rdata_b", bus.rdata_b, 32'hA5A5_A5A5);

        // Register 0 ignores writes and locks, including on the bypass path.
        idle();
        bus.we        = 1'b1;
        bus.waddr     = 4'd0;
        bus.wdata     = 32'hFFFF_FFFF;
        bus.lock_en   = 1'b1;
        bus.lock_addr = 4'd0;
        bus.rd_en     = 1'b1;
        bus.raddr_a   = 4'd0;
        tick();
        check("r0_byp_rdata", bus.rdata_a, 32'h0);
        check("r0_any_pending", {31'b0, bus.any_pending}, 32'h0);
        read(4'd0, 4'd0);
        check("r0_rdata", bus.rdata_a, 32'h0);
        check("r0_busy", {31'b0, bus.busy_a}, 32'h0);

        // Scoreboard: same-edge lock is not bypassed, later reads see busy.
        idle();
        bus.lock_en   = 1'b1;
        bus.lock_addr = 4'd4;
        bus.rd_en     = 1'b1;
        bus.raddr_a   = 4'd4;
        tick();
        check("lock4_same_edge_busy", {31'b0, bus.busy_a}, 32'h0);
        check("lock4_any_pending", {31'b0, bus.any_pending}, 32'h1);
        read(4'd4, 4'd0);
        check("lock4_busy_a", {31'b0, bus.busy_a}, 32'h1);
        write(4'd4, 32'h42);
        check("wr4_any_pending", {31'b0, bus.any_pending}, 32'h0);
        read(4'd0, 4'd4);
        check("wr4_rdata_b", bus.rdata_b, 32'h42);
        check("wr4_busy_b", {31'b0, bus.busy_b}, 32'h0);

        // Lock and write to the same register in one cycle: lock wins.
        idle();
        bus.lock_en   = 1'b1;
        bus.lock_addr = 4'd9;
        tick();
        idle();
        bus.we        = 1'b1;
        bus.waddr     = 4'd9;
        bus.wdata     = 32'h99;
        bus.lock_en   = 1'b1;
        bus.lock_addr = 4'd9;
        bus.rd_en     = 1'b1;
        bus.raddr_a   = 4'd9;
        tick();
        check("coll_byp_rdata", bus.rdata_a, 32'h99);
        check("coll_byp_busy", {31'b0, bus.busy_a}, 32'h1);
        check("coll_any_pending", {31'b0, bus.any_pending}, 32'h1);
        read(4'd9, 4'd9);
        check("coll_rdata_b", bus.rdata_b, 32'h99);
        check("coll_busy_b", {31'b0, bus.busy_b}, 32'h1);

        // Reset mid-operation discards an in-flight write and clears state.
        idle();
        rst       = 1'b1;
        bus.we    = 1'b1;
        bus.waddr = 4'd9;
        bus.wdata = 32'h5555_AAAA;
        tick();
        check("mid_rst_any", {31'b0, bus.any_pending}, 32'h0);
        check("mid_rst_rdata_b", bus.rdata_b, 32'h0);
        rst = 1'b0;
        read(4'd9, 4'd5);
        check("mid_rst_rd9", bus.rdata_a, 32'h0);
        check("mid_rst_busy9", {31'b0, bus.busy_a}, 32'h0);
        check("mid_rst_rd5", bus.rdata_b, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
